// File: rtl/cl_ocl_axil_mst_pkg.sv
// Shared types and constants for the OCL-style AXI4-Lite initiator.
// Used by cl_ocl_axil_master and its watchdog (CL_OCL_AXIL_MST_TIMEOUT_EN).
package cl_ocl_axil_mst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP,
        DRAIN
    } state_e;

    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
    localparam logic [31:0] TIMEOUT_RDATA   = 32'hDEAD_BEEF;

    function automatic logic is_wait(input state_e s);
        return (s == WR_ADDR_DATA) || (s == WR_RESP) ||
               (s == RD_ADDR) || (s == RD_DATA);
    endfunction

endpackage

// File: rtl/cl_ocl_axil_mst_wdog.sv
// Handshake watchdog: cleared by load, counts while enabled,
// flags expiry on its last count (used with CL_OCL_AXIL_MST_TIMEOUT_EN).
module cl_ocl_axil_mst_wdog #(
    parameter int CYCLES = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int            CW    = $clog2(CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/cl_ocl_axil_master.sv
// Single-outstanding AXI4-Lite initiator driven by a valid/ready command port.
// Optional handshake timeout and drain: `define CL_OCL_AXIL_MST_TIMEOUT_EN.
module cl_ocl_axil_master
    import cl_ocl_axil_mst_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_main_a0,
    input  logic              rst_main,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_wr,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              m_awvalid,
    output logic [ADDR_W-1:0] m_awaddr,
    input  logic              m_awready,
    output logic              m_wvalid,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_wready,
    input  logic              m_bvalid,
    input  logic [1:0]        m_bresp,
    output logic              m_bready,
    output logic              m_arvalid,
    output logic [ADDR_W-1:0] m_araddr,
    input  logic              m_arready,
    input  logic              m_rvalid,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    output logic              m_rready
`ifdef CL_OCL_AXIL_MST_TIMEOUT_EN
    ,
    output logic              timeout_seen
`endif
);

    state_e            r_state,     w_state;
    logic              r_wr,        w_wr;
    logic [ADDR_W-1:0] r_addr,      w_addr;
    logic [31:0]       r_wdata,     w_wdata;
    logic [3:0]        r_wstrb,     w_wstrb;
    logic              r_awvalid,   w_awvalid;
    logic              r_wvalid,    w_wvalid;
    logic              r_arvalid,   w_arvalid;
    logic              r_bready,    w_bready;
    logic              r_rready,    w_rready;
    logic              r_rsp_valid, w_rsp_valid;
    logic [31:0]       r_rsp_rdata, w_rsp_rdata;
    logic [1:0]        r_rsp_resp,  w_rsp_resp;

`ifdef CL_OCL_AXIL_MST_TIMEOUT_EN
    logic r_to, w_to;
    logic r_timeout_seen;
    logic w_to_hit;
    logic w_load;
    logic w_expire;

    cl_ocl_axil_mst_wdog #(
        .CYCLES   (TIMEOUT_CYCLES)
    ) u_wdog (
        .i_clk    (clk_main_a0),
        .i_rst    (rst_main),
        .i_load   (w_load),
        .i_en     (is_wait(r_state)),
        .o_expire (w_expire)
    );
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES >= 2) ^ (^TIMEOUT_RDATA) ^
                          (^AXI_RESP_SLVERR);
`endif

    always_comb begin
        w_state     = r_state;
        w_wr        = r_wr;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_wstrb     = r_wstrb;
        // a pending valid falls only once its own handshake has happened
        w_awvalid   = r_awvalid & ~m_awready;
        w_wvalid    = r_wvalid & ~m_wready;
        w_arvalid   = r_arvalid & ~m_arready;
        w_bready    = r_bready;
        w_rready    = r_rready;
        w_rsp_valid = r_rsp_valid;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_resp  = r_rsp_resp;
`ifdef CL_OCL_AXIL_MST_TIMEOUT_EN
        w_to        = r_to;
        w_to_hit    = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_wr    = cmd_wr;
                    w_addr  = cmd_addr;
                    w_wdata = cmd_wdata;
                    w_wstrb = cmd_wstrb;
                    if (cmd_wr) begin
                        w_awvalid = 1'b1;
                        w_wvalid  = 1'b1;
                        w_state   = WR_ADDR_DATA;
                    end else begin
                        w_arvalid = 1'b1;
                        w_state   = RD_ADDR;
                    end
                end
            end
            WR_ADDR_DATA: begin
                if (!w_awvalid && !w_wvalid) begin
                    w_bready = 1'b1;
                    w_state  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_bvalid && r_bready) begin
                    w_bready    = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_resp  = m_bresp;
                    w_rsp_rdata = '0;
                    w_state     = RSP;
                end
            end
            RD_ADDR: begin
                if (!w_arvalid) begin
                    w_rready = 1'b1;
                    w_state  = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_rvalid && r_rready) begin
                    w_rready    = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_resp  = m_rresp;
                    w_rsp_rdata = m_rdata;
                    w_state     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_state     = IDLE;
`ifdef CL_OCL_AXIL_MST_TIMEOUT_EN
                    if (r_to) begin
                        w_to     = 1'b0;
                        w_bready = r_wr;
                        w_rready = ~r_wr;
                        w_state  = DRAIN;
                    end
`endif
                end
            end
`ifdef CL_OCL_AXIL_MST_TIMEOUT_EN
            DRAIN: begin
                if (r_wr ? (m_bvalid && r_bready) : (m_rvalid && r_rready)) begin
                    w_bready = 1'b0;
                    w_rready = 1'b0;
                    w_state  = IDLE;
                end
            end
`endif
            default: begin
                w_state = IDLE;
            end
        endcase
`ifdef CL_OCL_AXIL_MST_TIMEOUT_EN
        // a handshake landing on the expiry cycle still wins
        if (w_expire && (w_state == r_state)) begin
            w_to_hit    = 1'b1;
            w_to        = 1'b1;
            w_bready    = 1'b0;
            w_rready    = 1'b0;
            w_rsp_valid = 1'b1;
            w_rsp_resp  = AXI_RESP_SLVERR;
            w_rsp_rdata = TIMEOUT_RDATA;
            w_state     = RSP;
        end
        w_load = (w_state != r_state) && is_wait(w_state);
`endif
    end

    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            r_state     <= IDLE;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= AXI_RESP_OKAY;
        end else begin
            r_state     <= w_state;
            r_wr        <= w_wr;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_wstrb     <= w_wstrb;
            r_awvalid   <= w_awvalid;
            r_wvalid    <= w_wvalid;
            r_arvalid   <= w_arvalid;
            r_bready    <= w_bready;
            r_rready    <= w_rready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_resp  <= w_rsp_resp;
        end
    end

`ifdef CL_OCL_AXIL_MST_TIMEOUT_EN
    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            r_to           <= 1'b0;
            r_timeout_seen <= 1'b0;
        end else begin
            r_to           <= w_to;
            r_timeout_seen <= r_timeout_seen | w_to_hit;
        end
    end

    assign timeout_seen = r_timeout_seen;
`endif

    assign cmd_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_wr    = r_wr;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;
    assign m_awvalid = r_awvalid;
    assign m_awaddr  = r_addr;
    assign m_wvalid  = r_wvalid;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = r_wstrb;
    assign m_bready  = r_bready;
    assign m_arvalid = r_arvalid;
    assign m_araddr  = r_addr;
    assign m_rready  = r_rready;

endmodule

// File: tb/tb_cl_ocl_axil_master.sv
// Bench for cl_ocl_axil_master: AXI-L slave model with wait knobs, memory
// reference model and directed plus randomized command sequences.
module tb_cl_ocl_axil_master;
    import cl_ocl_axil_mst_pkg::*;

    localparam int AW = 32;

    logic          clk_main_a0 = 1'b0;
    logic          rst_main    = 1'b1;
    logic          cmd_valid   = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr      = 1'b0;
    logic [AW-1:0] cmd_addr    = '0;
    logic [31:0]   cmd_wdata   = '0;
    logic [3:0]    cmd_wstrb   = '0;
    logic          rsp_valid;
    logic          rsp_ready   = 1'b0;
    logic          rsp_wr;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          m_awvalid;
    logic [AW-1:0] m_awaddr;
    logic          m_awready   = 1'b0;
    logic          m_wvalid;
    logic [31:0]   m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_wready    = 1'b0;
    logic          m_bvalid    = 1'b0;
    logic [1:0]    m_bresp     = '0;
    logic          m_bready;
    logic          m_arvalid;
    logic [AW-1:0] m_araddr;
    logic          m_arready   = 1'b0;
    logic          m_rvalid    = 1'b0;
    logic [31:0]   m_rdata     = '0;
    logic [1:0]    m_rresp     = '0;
    logic          m_rready;
`ifdef CL_OCL_AXIL_MST_TIMEOUT_EN
    logic          timeout_seen;
`endif

    always #5 clk_main_a0 = ~clk_main_a0;

    cl_ocl_axil_master #(
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_main_a0 (clk_main_a0),
        .rst_main    (rst_main),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_wr      (cmd_wr),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_wr      (rsp_wr),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .m_awvalid   (m_awvalid),
        .m_awaddr    (m_awaddr),
        .m_awready   (m_awready),
        .m_wvalid    (m_wvalid),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_wready    (m_wready),
        .m_bvalid    (m_bvalid),
        .m_bresp     (m_bresp),
        .m_bready    (m_bready),
        .m_arvalid   (m_arvalid),
        .m_araddr    (m_araddr),
        .m_arready   (m_arready),
        .m_rvalid    (m_rvalid),
        .m_rdata     (m_rdata),
        .m_rresp     (m_rresp),
`ifdef CL_OCL_AXIL_MST_TIMEOUT_EN
        .timeout_seen (timeout_seen),
`endif
        .m_rready    (m_rready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    bit          r_force = 0;
    logic [31:0] r_force_val = '0;
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    logic [31:0] smem [logic [31:0]];

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    initial begin
        bit          s_rst = 0, aw_got = 0, w_got = 0, ar_got = 0;
        bit          b_hs = 0, r_hs = 0;
        int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
        logic [31:0] aw_a = '0, w_d = '0, ar_a = '0, old;
        logic [3:0]  w_s = '0;
        forever begin
            @(posedge clk_main_a0);
            if (rst_main) s_rst = 1;
            else begin
                if (m_awvalid && m_awready) begin aw_got = 1; aw_a = m_awaddr; n_aw++; end
                if (m_wvalid && m_wready) begin
                    w_got = 1; w_d = m_wdata; w_s = m_wstrb; n_w++;
                end
                if (m_bvalid && m_bready) begin b_hs = 1; n_b++; end
                if (m_arvalid && m_arready) begin ar_got = 1; ar_a = m_araddr; n_ar++; end
                if (m_rvalid && m_rready) begin r_hs = 1; n_r++; end
            end
            @(negedge clk_main_a0);
            if (s_rst) begin
                s_rst = 0; aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                m_awready = 0; m_wready = 0; m_arready = 0;
                m_bvalid = 0; m_rvalid = 0;
            end else begin
                if (!m_awvalid) begin m_awready = 0; aw_cnt = 0; end
                else if (!m_awready) begin
                    if (aw_cnt >= aw_wait) m_awready = 1; else aw_cnt++;
                end
                if (!m_wvalid) begin m_wready = 0; w_cnt = 0; end
                else if (!m_wready) begin
                    if (w_cnt >= w_wait) m_wready = 1; else w_cnt++;
                end
                if (!m_arvalid) begin m_arready = 0; ar_cnt = 0; end
                else if (!m_arready) begin
                    if (ar_cnt >= ar_wait) m_arready = 1; else ar_cnt++;
                end
                if (b_hs) begin
                    m_bvalid = 0; b_hs = 0; aw_got = 0; w_got = 0; b_cnt = 0;
                end else if (!m_bvalid && aw_got && w_got) begin
                    if (b_cnt >= b_wait) begin
                        old = smem.exists(aw_a) ? smem[aw_a] : mem_init(aw_a);
                        for (int i = 0; i < 4; i++)
                            if (w_s[i]) old[i*8 +: 8] = w_d[i*8 +: 8];
                        smem[aw_a] = old;
                        m_bvalid = 1; m_bresp = cfg_bresp;
                    end else b_cnt++;
                end
                if (r_hs) begin
                    m_rvalid = 0; r_hs = 0; ar_got = 0; r_cnt = 0;
                end else if (!m_rvalid && ar_got) begin
                    if (r_cnt >= r_wait) begin
                        m_rvalid = 1; m_rresp = cfg_rresp;
                        if (r_force) m_rdata = r_force_val;
                        else m_rdata = smem.exists(ar_a) ? smem[ar_a] : mem_init(ar_a);
                    end else r_cnt++;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] rmem [logic [31:0]];

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : mem_init(a);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        rmem[a] = (model_read(a) & ~m) | (d & m);
    endfunction

    // ---------------- command / response helpers ----------------
    task automatic send_cmd(input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        int k = 0;
        @(negedge clk_main_a0);
        cmd_valid = 1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && k < 300) begin @(negedge clk_main_a0); k++; end
        if (k >= 300) chk("cmd_accept_bound", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        cmd_valid = 0;
    endtask

    task automatic get_rsp(input int hold, output logic w, output logic [31:0] d,
                           output logic [1:0] r);
        int k = 0;
        while (!rsp_valid && k < 300) begin @(negedge clk_main_a0); k++; end
        if (k >= 300) chk("rsp_bound", {63'd0, rsp_valid}, 64'd1);
        w = rsp_wr; d = rsp_rdata; r = rsp_resp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_main_a0);
            chk("rsp_stable", {rsp_valid, rsp_wr, rsp_rdata, rsp_resp, cmd_ready},
                {1'b1, w, d, r, 1'b0});
        end
        rsp_ready = 1;
        @(negedge clk_main_a0);
        rsp_ready = 0;
    endtask

    logic        ow, cw;
    logic [31:0] od, ca, cd, ed;
    logic [1:0]  orr, er;
    logic [3:0]  cs;
    int          s_aw, s_w, s_b, s_ar, s_r, nwr, nrd, k;

    initial begin
        rst_main = 1;
        repeat (3) @(negedge clk_main_a0);
        chk("reset_ctl", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                          rsp_valid, cmd_ready}, 7'b0000001);
        chk("reset_rsp", {rsp_wr, rsp_rdata, rsp_resp}, 35'd0);
        rst_main = 0;
        @(negedge clk_main_a0);

        // 1: zero-wait write, minimum latency
        send_cmd(1, 32'h500, 32'h0102_0304, 4'hF);
        chk("t1_aw_w_T1", {m_awvalid, m_wvalid, m_arvalid, cmd_ready}, 4'b1100);
        chk("t1_payload", {m_awaddr, m_wdata, m_wstrb}, {32'h500, 32'h0102_0304, 4'hF});
        @(negedge clk_main_a0);
        chk("t1_T2", {m_awvalid, m_wvalid, m_bready, rsp_valid}, 4'b0010);
        @(negedge clk_main_a0);
        chk("t1_T3", {rsp_valid, rsp_wr, rsp_resp, m_bready}, 5'b11000);
        chk("t1_rdata", rsp_rdata, 32'h0);
        rsp_ready = 1;
        @(negedge clk_main_a0);
        rsp_ready = 0;
        chk("t1_T4", {rsp_valid, cmd_ready}, 2'b01);
        model_write(32'h500, 32'h0102_0304, 4'hF);

        // 2: W accepted three cycles before AW
        aw_wait = 3; s_aw = n_aw; s_w = n_w; s_b = n_b;
        send_cmd(1, 32'h508, 32'hCAFE_F00D, 4'b0011);
        chk("t2_both_up", {m_awvalid, m_wvalid}, 2'b11);
        @(negedge clk_main_a0);
        chk("t2_w_dropped", {m_awvalid, m_wvalid}, 2'b10);
        repeat (2) @(negedge clk_main_a0);
        chk("t2_aw_held", {m_awvalid, m_wvalid, m_bready}, 3'b100);
        get_rsp(0, ow, od, orr);
        chk("t2_rsp", {ow, od, orr}, {1'b1, 32'h0, 2'b00});
        chk("t2_beats", {n_aw - s_aw, n_w - s_w, n_b - s_b}, {32'd1, 32'd1, 32'd1});
        model_write(32'h508, 32'hCAFE_F00D, 4'b0011);
        aw_wait = 0;

        // 3: slow read data, response back-pressured
        r_wait = 5; r_force = 1; r_force_val = 32'hAA55_0001;
        send_cmd(0, 32'h504, 32'h0, 4'h0);
        chk("t3_ar", {m_arvalid, m_awvalid, m_wvalid, m_araddr}, {3'b100, 32'h504});
        k = 0;
        while (!rsp_valid && k < 50) begin
            chk("t3_wait_cmd_ready", {63'd0, cmd_ready}, 64'd0);
            @(negedge clk_main_a0); k++;
        end
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold", {rsp_valid, rsp_wr, rsp_rdata, rsp_resp, cmd_ready},
                {1'b1, 1'b0, 32'hAA55_0001, 2'b00, 1'b0});
            @(negedge clk_main_a0);
        end
        get_rsp(0, ow, od, orr);
        chk("t3_rdata", od, 32'hAA55_0001);
        chk("t3_after", {rsp_valid, cmd_ready}, 2'b01);
        r_wait = 0; r_force = 0;

        // 4a: read error passes through without retry
        cfg_rresp = AXI_RESP_SLVERR; s_ar = n_ar;
        send_cmd(0, 32'h50C, 32'h0, 4'h0);
        get_rsp(1, ow, od, orr);
        chk("t4_slverr", {ow, orr}, {1'b0, 2'b10});
        chk("t4_rdata", od, model_read(32'h50C));
        repeat (3) @(negedge clk_main_a0);
        chk("t4_no_retry", n_ar - s_ar, 1);
        cfg_rresp = 2'b00;

        // 5: reset pulse while waiting for B
        b_wait = 10;
        send_cmd(1, 32'h510, 32'h1234_5678, 4'hF);
        k = 0;
        while (!m_bready && k < 20) begin @(negedge clk_main_a0); k++; end
        chk("t5_in_wr_resp", {63'd0, m_bready}, 64'd1);
        rst_main = 1;
        @(negedge clk_main_a0);
        rst_main = 0;
        chk("t5_after_rst", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                             rsp_valid, cmd_ready}, 7'b0000001);
        b_wait = 0;
        @(negedge clk_main_a0);

        // 4b: back-to-back random traffic against the memory model
        s_aw = n_aw; s_w = n_w; s_b = n_b; s_ar = n_ar; s_r = n_r;
        nwr = 0; nrd = 0;
        for (int i = 0; i < 100; i++) begin
            cw = 1'($urandom);
            ca = 32'h500 + 32'(4 * $urandom_range(0, 7));
            cd = $urandom;
            cs = 4'($urandom);
            aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3);
            ar_wait = $urandom_range(0, 3); b_wait = $urandom_range(0, 3);
            r_wait = $urandom_range(0, 3);
            cfg_bresp = 2'($urandom); cfg_rresp = 2'($urandom);
            if (cw) begin
                model_write(ca, cd, cs); ed = 32'h0; er = cfg_bresp; nwr++;
            end else begin
                ed = model_read(ca); er = cfg_rresp; nrd++;
            end
            send_cmd(cw, ca, cd, cs);
            get_rsp($urandom_range(0, 2), ow, od, orr);
            chk("rnd_wr", {63'd0, ow}, {63'd0, cw});
            chk("rnd_rdata", od, ed);
            chk("rnd_resp", orr, er);
        end
        repeat (3) @(negedge clk_main_a0);
        chk("rnd_wr_beats", {n_aw - s_aw, n_w - s_w, n_b - s_b}, {nwr, nwr, nwr});
        chk("rnd_rd_beats", {n_ar - s_ar, n_r - s_r}, {nrd, nrd});
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        cfg_bresp = 0; cfg_rresp = 0;

`ifdef CL_OCL_AXIL_MST_TIMEOUT_EN
        // 6: AR never accepted -> timeout response, then drain the late read
        ar_wait = 100000; s_r = n_r;
        send_cmd(0, 32'h520, 32'h0, 4'h0);
        k = 0;
        while (!rsp_valid && k < 100) begin @(negedge clk_main_a0); k++; end
        chk("t6_resp", {rsp_valid, rsp_resp}, 3'b110);
        chk("t6_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("t6_arvalid_held", {m_arvalid, timeout_seen}, 2'b11);
        rsp_ready = 1;
        @(negedge clk_main_a0);
        rsp_ready = 0;
        chk("t6_draining", {m_arvalid, cmd_ready}, 2'b10);
        ar_wait = 0;
        repeat (6) @(negedge clk_main_a0);
        chk("t6_drained", {cmd_ready, rsp_valid, m_rready}, 3'b100);
        chk("t6_late_r", n_r - s_r, 1);
        send_cmd(0, 32'h520, 32'h0, 4'h0);
        get_rsp(0, ow, od, orr);
        chk("t6_recover", {orr, od}, {2'b00, model_read(32'h520)});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
